ccntr_stage_seq: RTL

- Parametrised successor to the combinational CCntr control.
- Owns the read-side stage/step counters and a write-stage delay line internally, replacing externally supplied rd_stage/wr_stage/rd_lstep.
- Produces the registered counter-reset pulse and the source-address select from per-stage masks.
- Sits between the layer controller (start/cfg) and the accumulator/address counters of the dual-mode datapath.

---
 rtl/ccntr_pkg.sv | 33 +++
 rtl/stage_delay_line.sv | 49 ++++
 rtl/ccntr_stage_seq.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/ccntr_pkg.sv
// ---------------------------------------------------------------------------
// ccntr_pkg
// Shared definitions for the stage/step sequencer:
//   - FSM state encoding (IDLE, RUN, DRAIN, DONE)
//   - default per-stage masks for the counter-reset pulse and source select
//   - default counter widths and stage count
// ---------------------------------------------------------------------------
package ccntr_pkg;

  localparam int CCNTR_N_STAGE_DEF = 10;
  localparam int CCNTR_STAGE_W_DEF = 4;
  localparam int CCNTR_STEP_W_DEF  = 8;
  localparam int CCNTR_WR_LAG_DEF  = 2;

  // Stages 0,2,4,5,8 reset the downstream counters at their last step.
  localparam logic [CCNTR_N_STAGE_DEF-1:0] CCNTR_RST_MASK_DEF = 10'h135;
  // Stages 1,3 read from the alternate source address.
  localparam logic [CCNTR_N_STAGE_DEF-1:0] CCNTR_SRC_MASK_DEF = 10'h00A;

  typedef logic [1:0] ccntr_state_t;

  localparam ccntr_state_t ST_IDLE  = 2'd0;
  localparam ccntr_state_t ST_RUN   = 2'd1;
  localparam ccntr_state_t ST_DRAIN = 2'd2;
  localparam ccntr_state_t ST_DONE  = 2'd3;

  // The sequencer is busy while reading (RUN) and while the write side
  // catches up (DRAIN).
  function automatic logic ccntr_is_busy(input ccntr_state_t st);
    return (st == ST_RUN) || (st == ST_DRAIN);
  endfunction

endpackage

// File: rtl/stage_delay_line.sv
// ---------------------------------------------------------------------------
// stage_delay_line
// Fixed-depth shift register that delays a stage index by DEPTH clocks.
// Shifts on every clock; a synchronous clr flushes every tap to zero.
// Ports:
//   clk  - clock
//   rst  - asynchronous active-high reset (all taps to zero)
//   clr  - synchronous flush (all taps to zero)
//   din  - value entering the line
//   dout - din delayed by DEPTH clocks
// ---------------------------------------------------------------------------
module stage_delay_line
  import ccntr_pkg::*;
#(
  parameter int WIDTH = CCNTR_STAGE_W_DEF,
  parameter int DEPTH = CCNTR_WR_LAG_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_tap
      logic [WIDTH-1:0] tap_q;
      logic [WIDTH-1:0] tap_d;

      if (gi == 0) begin : g_first
        assign tap_d = clr ? '0 : din;
      end else begin : g_rest
        assign tap_d = clr ? '0 : g_tap[gi-1].tap_q;
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          tap_q <= '0;
        end else begin
          tap_q <= tap_d;
        end
      end
    end
  endgenerate

  assign dout = g_tap[DEPTH-1].tap_q;

endmodule

// File: rtl/ccntr_stage_seq.sv
// ---------------------------------------------------------------------------
// ccntr_stage_seq
// Stage/step sequencer for the dual-mode datapath. Counts steps within each
// read stage, advances through stages 0..last, lets the write side drain for
// WR_LAG cycles and then pulses done. Generates the registered counter-reset
// pulse and the source-address select from per-stage masks.
// Ports:
//   clk, rst         - clock, asynchronous active-high reset
//   start            - begin a sequence (accepted only in IDLE)
//   cfg_steps        - steps per stage, latched on start (0 treated as 1)
//   cfg_last         - final stage index, latched on start (clamped)
//   adv              - advance one step (honoured only in RUN)
//   clr              - synchronous abort, wins over start/adv
//   rst_in           - external counter-reset request, ORed into rst_out
//   busy             - high in RUN and DRAIN
//   done             - one-cycle pulse at sequence end
//   rd_stage         - current read stage
//   wr_stage         - rd_stage delayed WR_LAG cycles
//   rd_lstep         - last step of the current stage (RUN only)
//   rst_out          - registered counter reset
//   slc_source_addr  - registered SRC_MASK[wr_stage]
// ---------------------------------------------------------------------------
module ccntr_stage_seq
  import ccntr_pkg::*;
#(
  parameter int                 N_STAGE  = CCNTR_N_STAGE_DEF,
  parameter int                 STAGE_W  = CCNTR_STAGE_W_DEF,
  parameter int                 STEP_W   = CCNTR_STEP_W_DEF,
  parameter logic [N_STAGE-1:0] RST_MASK = CCNTR_RST_MASK_DEF,
  parameter logic [N_STAGE-1:0] SRC_MASK = CCNTR_SRC_MASK_DEF,
  parameter int                 WR_LAG   = CCNTR_WR_LAG_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [STEP_W-1:0]  cfg_steps,
  input  logic [STAGE_W-1:0] cfg_last,
  input  logic               adv,
  input  logic               clr,
  input  logic               rst_in,
  output logic               busy,
  output logic               done,
  output logic [STAGE_W-1:0] rd_stage,
  output logic [STAGE_W-1:0] wr_stage,
  output logic               rd_lstep,
  output logic               rst_out,
  output logic               slc_source_addr
);

  // Masks widened to the full index range so a STAGE_W-bit index selects
  // a bit without width mismatch; unused stages read as zero.
  localparam int                  MASK_W     = 2 ** STAGE_W;
  localparam logic [MASK_W-1:0]   RST_MASK_X = MASK_W'(RST_MASK);
  localparam logic [MASK_W-1:0]   SRC_MASK_X = MASK_W'(SRC_MASK);
  localparam logic [STAGE_W-1:0]  LAST_MAX   = STAGE_W'(N_STAGE - 1);
  localparam int                  DRAIN_W    = (WR_LAG > 1) ? $clog2(WR_LAG) : 1;
  localparam logic [DRAIN_W-1:0]  DRAIN_END  = DRAIN_W'(WR_LAG - 1);

  ccntr_state_t        state_q,    state_d;
  logic [STEP_W-1:0]   steps_q,    steps_d;
  logic [STAGE_W-1:0]  last_q,     last_d;
  logic [STAGE_W-1:0]  rd_stage_q, rd_stage_d;
  logic [STEP_W-1:0]   rd_step_q,  rd_step_d;
  logic [DRAIN_W-1:0]  drain_q,    drain_d;
  logic                rst_out_q,  rst_out_d;
  logic                slc_q,      slc_d;

  logic                lstep;
  logic [STAGE_W-1:0]  wr_stage_w;

  assign lstep = (state_q == ST_RUN) && (rd_step_q == (steps_q - STEP_W'(1)));

  always_comb begin
    state_d    = state_q;
    steps_d    = steps_q;
    last_d     = last_q;
    rd_stage_d = rd_stage_q;
    rd_step_d  = rd_step_q;
    drain_d    = drain_q;

    rst_out_d = rst_in || clr ||
                ((state_q == ST_RUN) && adv && lstep && RST_MASK_X[rd_stage_q]);
    slc_d     = SRC_MASK_X[wr_stage_w];

    if (clr) begin
      state_d    = ST_IDLE;
      steps_d    = '0;
      last_d     = '0;
      rd_stage_d = '0;
      rd_step_d  = '0;
      drain_d    = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d    = ST_RUN;
            steps_d    = (cfg_steps == '0) ? STEP_W'(1) : cfg_steps;
            last_d     = (cfg_last > LAST_MAX) ? LAST_MAX : cfg_last;
            rd_stage_d = '0;
            rd_step_d  = '0;
          end
        end

        ST_RUN: begin
          if (adv) begin
            if (lstep) begin
              rd_step_d = '0;
              if (rd_stage_q == last_q) begin
                // Final stage read out: hold rd_stage while write side drains.
                state_d = ST_DRAIN;
                drain_d = '0;
              end else begin
                rd_stage_d = rd_stage_q + STAGE_W'(1);
              end
            end else begin
              rd_step_d = rd_step_q + STEP_W'(1);
            end
          end
        end

        ST_DRAIN: begin
          if (drain_q == DRAIN_END) begin
            state_d = ST_DONE;
            drain_d = '0;
          end else begin
            drain_d = drain_q + DRAIN_W'(1);
          end
        end

        ST_DONE: begin
          state_d = ST_IDLE;
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      steps_q    <= '0;
      last_q     <= '0;
      rd_stage_q <= '0;
      rd_step_q  <= '0;
      drain_q    <= '0;
      rst_out_q  <= 1'b0;
      slc_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      steps_q    <= steps_d;
      last_q     <= last_d;
      rd_stage_q <= rd_stage_d;
      rd_step_q  <= rd_step_d;
      drain_q    <= drain_d;
      rst_out_q  <= rst_out_d;
      slc_q      <= slc_d;
    end
  end

  // Write stage follows the registered read stage, shifting every clock
  // regardless of adv so the lag is in cycles, not in steps.
  stage_delay_line #(
    .WIDTH (STAGE_W),
    .DEPTH (WR_LAG)
  ) u_wr_delay (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .din  (rd_stage_q),
    .dout (wr_stage_w)
  );

  assign busy            = ccntr_is_busy(state_q);
  assign done            = (state_q == ST_DONE);
  assign rd_stage        = rd_stage_q;
  assign wr_stage        = wr_stage_w;
  assign rd_lstep        = lstep;
  assign rst_out         = rst_out_q;
  assign slc_source_addr = slc_q;

endmodule
